adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Sequences one ADC capture into the 8-bit sample FIFO ahead of the SPI readout framer. It decodes host command bytes received over SPI and holds the capture configuration: length, decimation, trigger level and trigger mode. It arms on command, waits for a trigger, then gates the decimated samples into the FIFO. After the capture it holds off until the readout side reports the FIFO drained.

Parameters:
DEPTH, 1024, FIFO depth in samples; the capture length is clamped to this value
LEN_W, 16, width of the length register and sample counter
AUTO_TMO, 1000000, auto-trigger timeout in clk cycles; used only when ADC_CTRL_AUTO_TRIG_EN is defined

Ports:
clk  in  1  system clock
resetn  in  1  reset; synchronous, active-low
cmd_valid  in  1  one-cycle strobe: a command byte arrived from SPI
cmd_byte  in  8  command byte
smp_valid  in  1  one-cycle strobe: a new ADC sample, already synchronized to clk
smp_data  in  8  ADC sample
fifo_full  in  1  sample FIFO full
readout_done  in  1  one-cycle strobe from the readout side: FIFO drained
cap_wr_en  out  1  FIFO write strobe
cap_wr_data  out  8  FIFO write data
armed  out  1  high in the ARMED state
capturing  out  1  high in the CAPTURE state
cap_done  out  1  one-cycle pulse on entry to the DONE state
cmd_err  out  1  one-cycle pulse when an opcode is unknown

Behaviour:
- All outputs are registered. Every output resets to 0.
- Configuration registers reset as follows: len=DEPTH, decim=0, level=8'h80, mode=0.
- Command parser FSM: P_OP, P_ARG0, P_ARG1. It advances only on a cycle with cmd_valid.
  - 0xA0 ARM: accepted only when the capture FSM is in IDLE; otherwise ignored.
  - 0xA1 ABORT: forces the capture FSM to IDLE from any state.
  - 0xB0 LEN: two argument bytes follow, low byte first.
  - 0xB1 LEVEL: one argument byte.
  - 0xB2 DECIM: one argument byte.
  - 0xB3 MODE: one argument byte; bits[1:0] are used.
  - Any other opcode pulses cmd_err and the parser stays in P_OP.
  - A configuration write is ignored while the capture FSM is not IDLE. Its argument bytes are still consumed.
- Length rule: len==0 or len>DEPTH is stored as DEPTH.
- Capture FSM: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED on an accepted ARM. The sample counter, decimation counter and previous-sample register are cleared.
  - ARMED -> CAPTURE on a trigger. The triggering sample is the first sample written.
  - Trigger by mode:
    - 0: the first smp_valid.
    - 1 (rising): prev<level and cur>=level.
    - 2 (falling): prev>=level and cur<level.
    - 3: treated as 0.
  - The first sample after arming only loads prev; it cannot trigger in modes 1 and 2.
  - CAPTURE:
    - Keep 1 of every decim+1 valid samples, starting with the trigger sample.
    - A kept sample gives cap_wr_en=1 and cap_wr_data=smp_data on the next cycle (latency 1).
    - Increment the count on each write.
  - CAPTURE -> DONE when the count reaches len, or when fifo_full is seen while a write is pending. In the fifo_full case the write is dropped and the capture truncated.
  - cap_done pulses once, one cycle after the last write.
  - DONE -> IDLE on readout_done.
- Simultaneous events:
  - ABORT has priority over a trigger or completion in the same cycle.
  - An ABORT during CAPTURE gives no cap_done.
  - readout_done outside DONE is ignored.
- resetn low mid-capture: immediate return to IDLE, outputs 0, configuration back to defaults.

Optional Feature:
ADC_CTRL_AUTO_TRIG_EN
- Defined: a timeout counter runs in ARMED. After AUTO_TMO cycles without a trigger, the next smp_valid is treated as the trigger. The counter clears on leaving ARMED.
- Not defined: ARMED waits indefinitely; there is no counter logic.

Decomposition:
- Package adc_ctrl_pkg holds:
  - opcode constants (OP_ARM, OP_ABORT, OP_LEN, OP_LEVEL, OP_DECIM, OP_MODE);
  - trigger-mode constants;
  - capture-state and parser-state encodings (8-bit localparams).
- One sub-module, adc_trig_detect: registers the previous sample and outputs a one-cycle trig strobe, given mode, level and smp_valid. The parser and capture FSM stay in the top.

Test Plan:
- Defaults, ARM, 1024 ramp samples -> 1024 writes with data equal to the ramp; cap_done pulses once; no writes before ARM.
- LEN=0x0005, DECIM=2, MODE=0, ARM, samples 0..20 -> writes 0,3,6,9,12, then DONE; readout_done returns to IDLE.
- MODE=1, LEVEL=0x80, samples 0x70,0x7F,0x80,0x90 -> capture starts at 0x80. Same input with MODE=2 -> no trigger; armed stays 1.
- fifo_full asserted after 3 writes with LEN=10 -> DONE, exactly 3 writes, cap_done pulses.
- ABORT in the same cycle as a trigger sample -> IDLE, no write, no cap_done. LEN command sent while CAPTURE -> len unchanged; the next opcode decodes correctly.
- Opcode 0x55 -> cmd_err pulse. resetn low mid-CAPTURE -> all outputs 0 the next cycle; ADC_CTRL_AUTO_TRIG_EN build with AUTO_TMO=16 and flat input -> trigger after 16 cycles.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared constants for the ADC capture controller.
// Host opcodes, trigger modes, FSM state encodings and the length clamp helper.
package adc_ctrl_pkg;

  // Host command opcodes
  localparam logic [7:0] OP_ARM   = 8'hA0;
  localparam logic [7:0] OP_ABORT = 8'hA1;
  localparam logic [7:0] OP_LEN   = 8'hB0;
  localparam logic [7:0] OP_LEVEL = 8'hB1;
  localparam logic [7:0] OP_DECIM = 8'hB2;
  localparam logic [7:0] OP_MODE  = 8'hB3;

  // Trigger modes; mode 3 behaves like mode 0
  localparam logic [1:0] TM_FIRST     = 2'd0;
  localparam logic [1:0] TM_RISE      = 2'd1;
  localparam logic [1:0] TM_FALL      = 2'd2;
  localparam logic [1:0] TM_FIRST_ALT = 2'd3;

  // Capture FSM encoding
  typedef enum logic [7:0] {
    CS_IDLE    = 8'h00,
    CS_ARMED   = 8'h01,
    CS_CAPTURE = 8'h02,
    CS_DONE    = 8'h03
  } cap_state_t;

  // Command parser FSM encoding
  typedef enum logic [7:0] {
    P_OP   = 8'h00,
    P_ARG0 = 8'h01,
    P_ARG1 = 8'h02
  } parse_state_t;

  // A zero length or one larger than the FIFO means "fill the whole FIFO"
  function automatic int unsigned clamp_len(input int unsigned raw, input int unsigned depth);
    if (raw == 0 || raw > depth) return depth;
    return raw;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_trig.sv
// adc_trig_detect: trigger detector for the capture controller.
// Remembers the previous sample seen while armed and raises a one-cycle
// trigger strobe on the sample that satisfies the selected mode.
module adc_trig_detect
  import adc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_level,
  input  logic       i_smp_valid,
  input  logic [7:0] i_smp_data,
  output logic       o_trig
);

  logic [7:0] r_prev;
  logic       r_prev_vld;
  logic       w_cond;

  // Track the previous sample; arming forgets it so the first sample cannot fire an edge
  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_prev     <= 8'h00;
      r_prev_vld <= 1'b0;
    end else if (i_enable && i_smp_valid) begin
      r_prev     <= i_smp_data;
      r_prev_vld <= 1'b1;
    end
  end

  // Edge conditions need a real previous sample; the other modes fire on any sample
  always_comb begin
    w_cond = 1'b0;
    case (i_mode)
      TM_RISE:               w_cond = r_prev_vld && (r_prev <  i_level) && (i_smp_data >= i_level);
      TM_FALL:               w_cond = r_prev_vld && (r_prev >= i_level) && (i_smp_data <  i_level);
      TM_FIRST, TM_FIRST_ALT: w_cond = 1'b1;
      default:               w_cond = 1'b1;
    endcase
  end

  assign o_trig = i_enable && i_smp_valid && w_cond;

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: host command parser plus capture sequencer feeding the
// sample FIFO. Optional auto-trigger timeout is built when the macro
// ADC_CTRL_AUTO_TRIG_EN is defined.
module adc_capture_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int LEN_W    = 16,
  parameter int AUTO_TMO = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       smp_valid,
  input  logic [7:0] smp_data,
  input  logic       fifo_full,
  input  logic       readout_done,
  output logic       cap_wr_en,
  output logic [7:0] cap_wr_data,
  output logic       armed,
  output logic       capturing,
  output logic       cap_done,
  output logic       cmd_err
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  parse_state_t     r_pstate;
  cap_state_t       r_cstate;
  logic [7:0]       r_op;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [7:0]       r_decim;
  logic [7:0]       r_dcnt;
  logic [7:0]       r_level;
  logic [1:0]       r_mode;
  logic             r_cmd_err;
  logic             r_wr_en;
  logic [7:0]       r_wr_data;
  logic             r_done;
  logic             r_armed;
  logic             r_capturing;

  logic             w_op_cycle;
  logic             w_arm;
  logic             w_abort;
  logic             w_cfg_ok;
  logic             w_trig_det;
  logic             w_trig;
  logic [15:0]      w_len_raw;

  assign w_op_cycle = cmd_valid && (r_pstate == P_OP);
  assign w_arm      = w_op_cycle && (cmd_byte == OP_ARM) && (r_cstate == CS_IDLE);
  assign w_abort    = w_op_cycle && (cmd_byte == OP_ABORT);
  assign w_cfg_ok   = (r_cstate == CS_IDLE);
  assign w_len_raw  = {cmd_byte, r_len_lo};

  adc_trig_detect u_trig (
    .clk         (clk),
    .resetn      (resetn),
    .i_clear     (w_arm),
    .i_enable    (r_cstate == CS_ARMED),
    .i_mode      (r_mode),
    .i_level     (r_level),
    .i_smp_valid (smp_valid),
    .i_smp_data  (smp_data),
    .o_trig      (w_trig_det)
  );

`ifdef ADC_CTRL_AUTO_TRIG_EN
  localparam int             TMO_W = $clog2(AUTO_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_L = TMO_W'(AUTO_TMO);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Count cycles spent armed; saturate so the next sample after timeout triggers
  always_ff @(posedge clk) begin
    if (!resetn || r_cstate != CS_ARMED) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_L) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_trig = w_trig_det || ((r_cstate == CS_ARMED) && smp_valid && (r_tmo_cnt == TMO_L));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (AUTO_TMO == 0);
  assign w_trig       = w_trig_det;
`endif

  // Command parser: opcodes, argument bytes and the configuration registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pstate  <= P_OP;
      r_op      <= 8'h00;
      r_len_lo  <= 8'h00;
      r_len     <= DEPTH_L;
      r_decim   <= 8'h00;
      r_level   <= 8'h80;
      r_mode    <= 2'd0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (cmd_valid) begin
        case (r_pstate)
          P_OP: begin
            case (cmd_byte)
              OP_ARM, OP_ABORT: begin
              end
              OP_LEN, OP_LEVEL, OP_DECIM, OP_MODE: begin
                r_op     <= cmd_byte;
                r_pstate <= P_ARG0;
              end
              default: r_cmd_err <= 1'b1;
            endcase
          end
          P_ARG0: begin
            if (r_op == OP_LEN) begin
              r_len_lo <= cmd_byte;
              r_pstate <= P_ARG1;
            end else begin
              if (w_cfg_ok) begin
                case (r_op)
                  OP_LEVEL: r_level <= cmd_byte;
                  OP_DECIM: r_decim <= cmd_byte;
                  OP_MODE:  r_mode  <= cmd_byte[1:0];
                  default: begin
                  end
                endcase
              end
              r_pstate <= P_OP;
            end
          end
          P_ARG1: begin
            if (w_cfg_ok) begin
              r_len <= LEN_W'(clamp_len(32'(w_len_raw), DEPTH));
            end
            r_pstate <= P_OP;
          end
          default: r_pstate <= P_OP;
        endcase
      end
    end
  end

  // Capture sequencer: arm, wait for trigger, gate decimated samples, hold until drained
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cstate    <= CS_IDLE;
      r_armed     <= 1'b0;
      r_capturing <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= 8'h00;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_dcnt      <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (w_abort) begin
        r_cstate    <= CS_IDLE;
        r_armed     <= 1'b0;
        r_capturing <= 1'b0;
      end else begin
        case (r_cstate)
          CS_IDLE: begin
            if (w_arm) begin
              r_cstate <= CS_ARMED;
              r_armed  <= 1'b1;
              r_count  <= '0;
              r_dcnt   <= 8'h00;
            end
          end
          CS_ARMED: begin
            if (w_trig) begin
              r_armed <= 1'b0;
              r_dcnt  <= r_decim;
              if (fifo_full) begin
                r_cstate <= CS_DONE;
                r_done   <= 1'b1;
              end else begin
                r_cstate    <= CS_CAPTURE;
                r_capturing <= 1'b1;
                r_wr_en     <= 1'b1;
                r_wr_data   <= smp_data;
                r_count     <= LEN_W'(1);
              end
            end
          end
          CS_CAPTURE: begin
            if (r_count >= r_len) begin
              r_cstate    <= CS_DONE;
              r_capturing <= 1'b0;
              r_done      <= 1'b1;
            end else if (smp_valid) begin
              if (r_dcnt == 8'h00) begin
                r_dcnt <= r_decim;
                if (fifo_full) begin
                  r_cstate    <= CS_DONE;
                  r_capturing <= 1'b0;
                  r_done      <= 1'b1;
                end else begin
                  r_wr_en   <= 1'b1;
                  r_wr_data <= smp_data;
                  r_count   <= r_count + LEN_W'(1);
                end
              end else begin
                r_dcnt <= r_dcnt - 8'd1;
              end
            end
          end
          CS_DONE: begin
            if (readout_done) begin
              r_cstate <= CS_IDLE;
            end
          end
          default: r_cstate <= CS_IDLE;
        endcase
      end
    end
  end

  assign cap_wr_en   = r_wr_en;
  assign cap_wr_data = r_wr_data;
  assign armed       = r_armed;
  assign capturing   = r_capturing;
  assign cap_done    = r_done;
  assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed self-checking bench for adc_capture_ctrl.
// Inputs change 2 time units after the rising edge; outputs are logged on the falling edge.
module tb_adc_capture_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       smp_valid = 1'b0;
  logic [7:0] smp_data = 8'h00;
  logic       fifo_full = 1'b0;
  logic       readout_done = 1'b0;
  logic       cap_wr_en;
  logic [7:0] cap_wr_data;
  logic       armed;
  logic       capturing;
  logic       cap_done;
  logic       cmd_err;

  int         total = 0;
  int         bad = 0;
  logic [7:0] wr_q[$];
  int         done_cnt = 0;

  adc_capture_ctrl #(.DEPTH(1024), .LEN_W(16), .AUTO_TMO(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_byte     (cmd_byte),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .fifo_full    (fifo_full),
    .readout_done (readout_done),
    .cap_wr_en    (cap_wr_en),
    .cap_wr_data  (cap_wr_data),
    .armed        (armed),
    .capturing    (capturing),
    .cap_done     (cap_done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  // Log every FIFO write and every cap_done pulse
  always @(negedge clk) begin
    if (cap_wr_en === 1'b1) wr_q.push_back(cap_wr_data);
    if (cap_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_smp(input logic [7:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    step();
    smp_valid = 1'b0;
  endtask

  task automatic pulse_readout();
    readout_done = 1'b1;
    step();
    readout_done = 1'b0;
  endtask

  task automatic clear_log();
    wr_q.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step(); step();
    total++;
    if ({cap_wr_en, cap_wr_data, armed, capturing, cap_done, cmd_err} !== 13'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {cap_wr_en, cap_wr_data, armed, capturing, cap_done, cmd_err});
    end
    resetn = 1'b1;
    step();
    clear_log();
    for (int i = 0; i < 5; i++) send_smp(8'(i + 8'h40));
    step(); step();
    total++;
    if (wr_q.size() != 0 || armed !== 1'b0) begin
      bad++;
      $display("[TB] FAIL no_write_before_arm: writes=%0d armed=%b expected 0 and 0", wr_q.size(), armed);
    end
  endtask

  task automatic test_default_ramp();
    int nbad;
    clear_log();
    send_cmd(8'hA0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("[TB] FAIL arm_default: armed=%b expected 1", armed);
    end
    for (int i = 0; i < 1024; i++) send_smp(8'(i));
    step(); step(); step();
    total++;
    if (wr_q.size() != 1024) begin
      bad++;
      $display("[TB] FAIL ramp_count: writes=%0d expected 1024", wr_q.size());
    end
    nbad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== 8'(i)) nbad++;
    total++;
    if (nbad != 0) begin
      bad++;
      $display("[TB] FAIL ramp_data: %0d wrong bytes expected 0", nbad);
    end
    total++;
    if (done_cnt != 1 || capturing !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ramp_done: done_pulses=%0d capturing=%b expected 1 and 0", done_cnt, capturing);
    end
    send_cmd(8'hA0);
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("[TB] FAIL arm_in_done: armed=%b expected 0", armed);
    end
    pulse_readout();
    send_cmd(8'hA0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rearm_after_readout: armed=%b expected 1", armed);
    end
    send_cmd(8'hA1);
  endtask

  task automatic test_decim();
    logic [7:0] exp_q[$];
    exp_q = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd12};
    clear_log();
    send_cmd(8'hB0); send_cmd(8'h05); send_cmd(8'h00);
    send_cmd(8'hB2); send_cmd(8'h02);
    send_cmd(8'hB3); send_cmd(8'h00);
    send_cmd(8'hA0);
    for (int i = 0; i <= 20; i++) send_smp(8'(i));
    step(); step(); step();
    total++;
    if (wr_q.size() != 5) begin
      bad++;
      $display("[TB] FAIL decim_count: writes=%0d expected 5", wr_q.size());
    end
    for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
      total++;
      if (wr_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL decim_data[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("[TB] FAIL decim_done: done_pulses=%0d expected 1", done_cnt);
    end
    pulse_readout();
    send_cmd(8'hA0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("[TB] FAIL decim_back_to_idle: armed=%b expected 1", armed);
    end
    send_cmd(8'hA1);
  endtask

  task automatic test_trigger_modes();
    clear_log();
    send_cmd(8'hB2); send_cmd(8'h00);
    send_cmd(8'hB0); send_cmd(8'h0A); send_cmd(8'h00);
    send_cmd(8'hB1); send_cmd(8'h80);
    send_cmd(8'hB3); send_cmd(8'h01);
    send_cmd(8'hA0);
    send_smp(8'h70); send_smp(8'h7F); send_smp(8'h80); send_smp(8'h90);
    step();
    total++;
    if (wr_q.size() != 2 || wr_q.size() == 2 && (wr_q[0] !== 8'h80 || wr_q[1] !== 8'h90)) begin
      bad++;
      $display("[TB] FAIL rising_start: writes=%0d first=%h expected 2 writes 80,90",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'hXX);
    end
    total++;
    if (capturing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rising_capturing: capturing=%b expected 1", capturing);
    end
    send_cmd(8'hA1);
    step();
    total++;
    if (capturing !== 1'b0 || done_cnt != 0) begin
      bad++;
      $display("[TB] FAIL abort_capture: capturing=%b done_pulses=%0d expected 0 and 0", capturing, done_cnt);
    end
    // First sample after arming only seeds the previous value
    clear_log();
    send_cmd(8'hA0);
    send_smp(8'h90);
    step();
    total++;
    if (armed !== 1'b1 || wr_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL first_sample_no_trig: armed=%b writes=%0d expected 1 and 0", armed, wr_q.size());
    end
    send_smp(8'h70); send_smp(8'h85);
    step();
    total++;
    if (wr_q.size() != 1 || wr_q.size() == 1 && wr_q[0] !== 8'h85) begin
      bad++;
      $display("[TB] FAIL rising_after_seed: writes=%0d expected 1 write of 85", wr_q.size());
    end
    send_cmd(8'hA1);
    // Falling mode sees no falling edge in an upward ramp
    clear_log();
    send_cmd(8'hB3); send_cmd(8'h02);
    send_cmd(8'hA0);
    send_smp(8'h70); send_smp(8'h7F); send_smp(8'h80); send_smp(8'h90);
    step();
    total++;
    if (armed !== 1'b1 || wr_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL falling_no_trig: armed=%b writes=%0d expected 1 and 0", armed, wr_q.size());
    end
    send_smp(8'h60);
    step();
    total++;
    if (wr_q.size() != 1 || wr_q.size() == 1 && wr_q[0] !== 8'h60) begin
      bad++;
      $display("[TB] FAIL falling_trig: writes=%0d expected 1 write of 60", wr_q.size());
    end
    send_cmd(8'hA1);
  endtask

  task automatic test_fifo_full();
    clear_log();
    send_cmd(8'hB3); send_cmd(8'h00);
    send_cmd(8'hA0);
    send_smp(8'h01); send_smp(8'h02); send_smp(8'h03);
    fifo_full = 1'b1;
    send_smp(8'h04);
    step(); step();
    fifo_full = 1'b0;
    total++;
    if (wr_q.size() != 3 || wr_q.size() == 3 && (wr_q[0] !== 8'h01 || wr_q[1] !== 8'h02 || wr_q[2] !== 8'h03)) begin
      bad++;
      $display("[TB] FAIL full_truncate: writes=%0d expected 3 writes 01,02,03", wr_q.size());
    end
    total++;
    if (done_cnt != 1 || capturing !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_done: done_pulses=%0d capturing=%b expected 1 and 0", done_cnt, capturing);
    end
    pulse_readout();
  endtask

  task automatic test_abort_trigger();
    clear_log();
    send_cmd(8'hA0);
    cmd_valid = 1'b1; cmd_byte = 8'hA1;
    smp_valid = 1'b1; smp_data = 8'h42;
    step();
    cmd_valid = 1'b0; smp_valid = 1'b0;
    step(); step(); step();
    total++;
    if (armed !== 1'b0 || capturing !== 1'b0 || wr_q.size() != 0 || done_cnt != 0) begin
      bad++;
      $display("[TB] FAIL abort_vs_trigger: armed=%b capturing=%b writes=%0d done=%0d expected all 0",
               armed, capturing, wr_q.size(), done_cnt);
    end
    send_cmd(8'hA0);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_to_idle: armed=%b expected 1", armed);
    end
    send_cmd(8'hA1);
  endtask

  task automatic test_cfg_locked();
    clear_log();
    send_cmd(8'hB0); send_cmd(8'h03); send_cmd(8'h00);
    send_cmd(8'hA0);
    send_smp(8'h11);
    send_cmd(8'hB0); send_cmd(8'h01); send_cmd(8'h00);
    send_cmd(8'h55);
    total++;
    if (cmd_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bad_opcode_err: cmd_err=%b expected 1", cmd_err);
    end
    step();
    total++;
    if (cmd_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cmd_err_pulse: cmd_err=%b expected 0", cmd_err);
    end
    send_smp(8'h22); send_smp(8'h33);
    step(); step(); step();
    total++;
    if (wr_q.size() != 3 || done_cnt != 1) begin
      bad++;
      $display("[TB] FAIL len_locked: writes=%0d done=%0d expected 3 and 1", wr_q.size(), done_cnt);
    end
    pulse_readout();
  endtask

  task automatic test_len_clamp();
    logic [15:0] raw_q[$];
    raw_q = '{16'h0000, 16'h0401};
    for (int k = 0; k < 2; k++) begin
      clear_log();
      send_cmd(8'hB0); send_cmd(raw_q[k][7:0]); send_cmd(raw_q[k][15:8]);
      send_cmd(8'hA0);
      for (int i = 0; i < 1030; i++) send_smp(8'(i));
      step(); step(); step();
      total++;
      if (wr_q.size() != 1024 || done_cnt != 1) begin
        bad++;
        $display("[TB] FAIL len_clamp_%h: writes=%0d done=%0d expected 1024 and 1", raw_q[k], wr_q.size(), done_cnt);
      end
      pulse_readout();
    end
    clear_log();
    send_cmd(8'hB0); send_cmd(8'h01); send_cmd(8'h00);
    send_cmd(8'hA0);
    send_smp(8'hAA); send_smp(8'hBB); send_smp(8'hCC);
    step(); step();
    total++;
    if (wr_q.size() != 1 || done_cnt != 1) begin
      bad++;
      $display("[TB] FAIL len_one: writes=%0d done=%0d expected 1 and 1", wr_q.size(), done_cnt);
    end
    pulse_readout();
  endtask

  task automatic test_reset_mid();
    clear_log();
    send_cmd(8'hB2); send_cmd(8'h02);
    send_cmd(8'hB3); send_cmd(8'h01);
    send_cmd(8'hB1); send_cmd(8'h10);
    send_cmd(8'hB0); send_cmd(8'h05); send_cmd(8'h00);
    send_cmd(8'hA0);
    send_smp(8'h00); send_smp(8'h20); send_smp(8'h21); send_smp(8'h22);
    total++;
    if (capturing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid_setup: capturing=%b expected 1", capturing);
    end
    resetn = 1'b0;
    smp_valid = 1'b1; smp_data = 8'h77;
    step();
    smp_valid = 1'b0;
    total++;
    if ({cap_wr_en, cap_wr_data, armed, capturing, cap_done, cmd_err} !== 13'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid_outputs: got %b expected all zero",
               {cap_wr_en, cap_wr_data, armed, capturing, cap_done, cmd_err});
    end
    resetn = 1'b1;
    step();
    clear_log();
    send_cmd(8'hA0);
    send_smp(8'h05); send_smp(8'h06); send_smp(8'h07);
    step(); step();
    total++;
    if (wr_q.size() != 3 || wr_q.size() == 3 && (wr_q[0] !== 8'h05 || wr_q[2] !== 8'h07) || capturing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_cfg_defaults: writes=%0d capturing=%b expected 3 writes 05..07 and 1",
               wr_q.size(), capturing);
    end
    send_cmd(8'hA1);
  endtask

`ifdef ADC_CTRL_AUTO_TRIG_EN
  task automatic test_auto_trig();
    clear_log();
    send_cmd(8'hB3); send_cmd(8'h01);
    send_cmd(8'hA0);
    for (int i = 0; i < 10; i++) send_smp(8'h10);
    total++;
    if (capturing !== 1'b0) begin
      bad++;
      $display("[TB] FAIL auto_trig_early: capturing=%b expected 0", capturing);
    end
    for (int i = 0; i < 12; i++) send_smp(8'h10);
    total++;
    if (capturing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL auto_trig_fire: capturing=%b expected 1", capturing);
    end
    send_cmd(8'hA1);
  endtask
`endif

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_default_ramp();
    test_decim();
    test_trigger_modes();
    test_fifo_full();
    test_abort_trigger();
    test_cfg_locked();
    test_len_clamp();
    test_reset_mid();
`ifdef ADC_CTRL_AUTO_TRIG_EN
    test_auto_trig();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
